// File: rtl/gate_pkg.sv
// Shared definitions for the gate truth-table checker: function encodings,
// controller states and the golden two-input gate function.
package gate_pkg;

  localparam logic [1:0] FUNC_AND  = 2'b00;
  localparam logic [1:0] FUNC_OR   = 2'b01;
  localparam logic [1:0] FUNC_XOR  = 2'b10;
  localparam logic [1:0] FUNC_NAND = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic expected_out(input logic [1:0] func_sel,
                                        input logic a,
                                        input logic b);
    logic y;
    case (func_sel)
      FUNC_AND: y = a & b;
      FUNC_OR:  y = a | b;
      FUNC_XOR: y = a ^ b;
      default:  y = ~(a & b);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: the output the gate under test should produce
// for the latched function and the operands currently being driven.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic [1:0] func_sel,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  assign expected = expected_out(func_sel, a, b);

endmodule

// File: rtl/gate_checker.sv
// Walks a two-input gate through all four operand vectors, holds each for
// SETTLE cycles, then compares the gate output against the golden function.
module gate_checker
  import gate_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] func_sel,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] ERR_MAX     = 3'd4;

  state_e     state_q, state_d;
  logic [1:0] func_q, func_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] settle_q, settle_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       done_q, done_d;
  logic       exp_out;

  gate_ref_model u_ref_model (
    .func_sel (func_q),
    .a        (idx_q[1]),
    .b        (idx_q[0]),
    .expected (exp_out)
  );

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          func_d   = func_sel;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          idx_d    = '0;
          settle_d = '0;
          state_d  = ST_APPLY;
        end
      end

      ST_APPLY: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = ST_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      ST_CHECK: begin
        // An abort here skips the compare so the results stay frozen.
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (dut_out != exp_out) begin
            fail_d[idx_q] = 1'b1;
            if (err_q != ERR_MAX) err_d = err_q + 3'd1;
          end
          if (idx_q == 2'd3) begin
            state_d = ST_DONE;
          end else begin
            idx_d    = idx_q + 2'd1;
            settle_d = '0;
            state_d  = ST_APPLY;
          end
        end
      end

      default: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 3'd0);
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      func_q   <= '0;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fail_q   <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == ST_APPLY) || (state_q == ST_CHECK);
  assign dut_a     = busy & idx_q[1];
  assign dut_b     = busy & idx_q[0];
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: a behavioural two-input gate whose truth table can be
// swapped per run, checked against a truth-table model of the expected results.
module tb_gate_checker;

  localparam int unsigned SETTLE = 2;
  localparam int LATENCY = 4 * (SETTLE + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [1:0] func_sel;
  logic       dut_a;
  logic       dut_b;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  logic [3:0] gate_tt;
  logic [1:0] gate_idx;
  int         n_compared = 0;
  int         n_mismatched = 0;

  gate_checker #(.SETTLE(SETTLE)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .func_sel  (func_sel),
    .dut_a     (dut_a),
    .dut_b     (dut_b),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  // The gate under test is a truth table: bit i is the output for {a,b} = i.
  assign gate_idx = {dut_a, dut_b};
  assign dut_out  = gate_tt[gate_idx];

  always #5 clk = ~clk;

  function automatic logic [3:0] truth_table(input logic [1:0] f);
    case (f)
      2'b00:   return 4'b1000;
      2'b01:   return 4'b1110;
      2'b10:   return 4'b0110;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full run: start (optionally with abort), optional mid-run start or
  // abort at a given cycle count after the accepting edge, then result checks.
  task automatic apply_stimulus(input logic [1:0] func, input logic [3:0] tt,
                                input int mid_start, input int abort_at,
                                input bit abort_with_start, input bit log_vec);
    logic [3:0] exp_fail;
    logic [3:0] done_mask;
    logic [1:0] seen[$];
    logic [1:0] last_vec;
    int         cyc;
    int         done_cyc;
    bit         seq_ok;
    logic       busy_after_abort;

    gate_tt   = tt;
    done_mask = 4'b1111;
    if (abort_at >= 0) begin
      done_mask = 4'b0000;
      for (int k = 0; k < 4; k++)
        if (int'((SETTLE + 1) * k + SETTLE) < abort_at) done_mask[k] = 1'b1;
    end
    exp_fail = (truth_table(func) ^ tt) & done_mask;

    @(negedge clk);
    func_sel = func;
    start    = 1'b1;
    abort    = abort_with_start;
    @(posedge clk);
    #1;
    start    = 1'b0;
    abort    = 1'b0;
    func_sel = 2'($urandom_range(0, 3));

    cyc = 0;
    done_cyc = -1;
    busy_after_abort = 1'bx;
    last_vec = 2'bxx;
    seen.delete();
    while (cyc < 60 && done_cyc < 0) begin
      if (busy) begin
        seen.push_back({dut_a, dut_b});
        if (log_vec && ({dut_a, dut_b} !== last_vec))
          $display("[TB] stimulus vector %b%b at cycle %0d", dut_a, dut_b, cyc);
        last_vec = {dut_a, dut_b};
      end
      start = (cyc == mid_start);
      abort = (cyc == abort_at);
      if (cyc == mid_start) func_sel = ~func;
      @(posedge clk);
      cyc++;
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (cyc == abort_at + 1) busy_after_abort = busy;
      if (done) done_cyc = cyc;
    end

    if (abort_at < 0) begin
      check_output("done_latency", done_cyc, LATENCY);
      check_output("pass", 32'(pass), 32'(exp_fail == 4'b0000));
      check_output("err_count", 32'(err_count), $countones(exp_fail));
      check_output("fail_vec", 32'(fail_vec), 32'(exp_fail));
      seq_ok = (seen.size() == 4 * (SETTLE + 1));
      for (int j = 0; j < seen.size(); j++)
        if (seen[j] !== 2'(j / (SETTLE + 1))) seq_ok = 1'b0;
      check_output("vector_order", 32'(seq_ok), 32'd1);
      @(posedge clk);
      #1;
      check_output("done_one_cycle", 32'(done), 32'd0);
    end else begin
      check_output("abort_no_done", done_cyc, -1);
      check_output("abort_busy_low", 32'(busy_after_abort), 32'd0);
      check_output("abort_pass", 32'(pass), 32'd0);
      check_output("abort_err_count", 32'(err_count), $countones(exp_fail));
      check_output("abort_fail_vec", 32'(fail_vec), 32'(exp_fail));
    end
  endtask

  initial begin
    int cyc;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    func_sel = 2'b00;
    gate_tt  = 4'b1110;

    repeat (3) @(negedge clk);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_pass", 32'(pass), 32'd0);
    check_output("reset_err", 32'(err_count), 32'd0);
    check_output("reset_fail", 32'(fail_vec), 32'd0);
    check_output("reset_ops", 32'({dut_a, dut_b}), 32'd0);
    rst_n = 1'b1;

    $display("[TB] OR gate, func OR");
    apply_stimulus(2'b01, 4'b1110, -1, -1, 1'b0, 1'b1);
    $display("[TB] OR gate, func AND");
    apply_stimulus(2'b00, 4'b1110, -1, -1, 1'b0, 1'b0);
    $display("[TB] OR gate, func NAND");
    apply_stimulus(2'b11, 4'b1110, -1, -1, 1'b0, 1'b0);
    $display("[TB] AND gate, func NAND (all vectors wrong)");
    apply_stimulus(2'b11, 4'b1000, -1, -1, 1'b0, 1'b0);
    $display("[TB] OR gate, start pulse mid-check");
    apply_stimulus(2'b01, 4'b1110, 5, -1, 1'b0, 1'b0);
    $display("[TB] OR gate, abort together with start");
    apply_stimulus(2'b10, 4'b1110, -1, -1, 1'b1, 1'b0);
    $display("[TB] OR gate, abort in second APPLY");
    apply_stimulus(2'b11, 4'b1110, -1, 3, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++)
      apply_stimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), -1, -1, 1'b0, 1'b0);

    // Reset while vector 2 is in its compare cycle.
    $display("[TB] reset during CHECK of vector 2");
    gate_tt = 4'b1110;
    @(negedge clk);
    func_sel = 2'b11;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    while (cyc < int'(2 * (SETTLE + 1) + SETTLE)) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check_output("pre_reset_ops", 32'({dut_a, dut_b}), 32'd2);
    rst_n = 1'b0;
    #1;
    check_output("async_reset_outputs",
                 32'({busy, done, pass, err_count, fail_vec, dut_a, dut_b}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(2'b01, 4'b1110, -1, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
